// File: rtl/fta_bus_pkg.sv
// Shared FTA bus command types used by the request queue and its storage.
package fta_bus_pkg;

   typedef struct packed {
      logic [3:0] core;
      logic [2:0] channel;
      logic [7:0] tranid;
   } fta_tranid_t;

   typedef struct packed {
      fta_tranid_t   tid;
      logic          cyc;
      logic          stb;
      logic          we;
      logic [15:0]   sel;
      logic [31:0]   padr;
      logic [127:0]  dat;
   } fta_cmd_request128_t;

   typedef struct packed {
      fta_tranid_t   tid;
      logic          ack;
      logic          rty;
      logic [31:0]   adr;
      logic [127:0]  dat;
   } fta_cmd_response128_t;

endpackage

// File: rtl/fta_reqq_store.sv
// Request storage: DEPTH x request register array, one write port, one async read port.
module fta_reqq_store
   import fta_bus_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                we_i,
   input  logic [AW-1:0]       waddr_i,
   input  fta_cmd_request128_t wdata_i,
   input  logic [AW-1:0]       raddr_i,
   output fta_cmd_request128_t rdata_o
);

   fta_cmd_request128_t mem_q [DEPTH];

   // Capture an accepted request into its slot.
   // NOTE: payload storage has no reset; validity is tracked by the pointers/count, so clearing data buys nothing.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fta_req_queue.sv
// Registered request queue between the MPU arbiter and the system bus.
// Upstream sees an immediate accept/retry based only on fullness; downstream
// sees the head entry held stable until the bus stops retrying it. Bus
// responses return upstream through a single register stage.
module fta_req_queue
   import fta_bus_pkg::*;
#(
   parameter  int DEPTH       = 4,   // power of two, >= 2
   parameter  int RETRY_LIMIT = 15,
   localparam int AW          = $clog2(DEPTH),
   localparam int CW          = AW + 1,
   localparam int RW          = $clog2(RETRY_LIMIT + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  fta_cmd_request128_t  up_req,
   output fta_cmd_response128_t up_resp,
   output fta_cmd_request128_t  dn_req,
   input  fta_cmd_response128_t dn_resp,
   output logic                 full_o,
   output logic                 empty_o,
   output logic [CW-1:0]        count_o,
   output logic                 retry_err_o
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      STALL
   } state_e;

   state_e               state_q, state_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [RW-1:0]        rcnt_q, rcnt_d;
   logic                 err_q, err_d;
   fta_cmd_response128_t resp_q, resp_d;

   logic                 full;
   logic                 push;
   logic                 pop;
   fta_cmd_request128_t  head;

   // Fullness alone decides accept/retry, so no downstream path reaches up_resp.rty.
   assign full = (count_q == CW'(DEPTH));
   assign push = up_req.cyc & ~full;

   fta_reqq_store #(.DEPTH(DEPTH)) u_store (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (up_req),
      .raddr_i (rd_ptr_q),
      .rdata_o (head)
   );

   // FSM state register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state: leave IDLE as soon as anything is queued, stall while the bus retries.
   always_comb begin
      // NOTE: default assignment first keeps this combinational block free of latches.
      state_d = state_q;
      unique case (state_q)
         IDLE:         if (count_d != '0) state_d = ISSUE;
         ISSUE, STALL: begin
            if (dn_resp.rty)         state_d = STALL;
            else if (count_d != '0)  state_d = ISSUE;
            else                     state_d = IDLE;
         end
         default:                    state_d = IDLE;
      endcase
   end

   // FSM outputs: present the head entry while issuing; pop when the bus does not retry.
   always_comb begin
      dn_req = '0;
      pop    = 1'b0;
      if (state_q != IDLE) begin
         dn_req = head;
         pop    = ~dn_resp.rty;
      end
   end

   // Pointer and occupancy update; simultaneous push and pop leave count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Consecutive-retry counter on the head entry and the sticky error it raises.
   always_comb begin
      rcnt_d = rcnt_q;
      if (state_q != IDLE) begin
         if (!dn_resp.rty)                   rcnt_d = '0;
         else if (rcnt_q != RW'(RETRY_LIMIT)) rcnt_d = rcnt_q + 1'b1;
      end
      err_d = err_q | (rcnt_d == RW'(RETRY_LIMIT));
   end

   // Response stage: pass the bus response through with its retry bit cleared.
   always_comb begin
      resp_d     = dn_resp;
      resp_d.rty = 1'b0;
   end

   // Queue bookkeeping, retry tracking and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rcnt_q   <= '0;
         err_q    <= 1'b0;
         resp_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rcnt_q   <= rcnt_d;
         err_q    <= err_d;
         resp_q   <= resp_d;
      end
   end

   // Upstream response: registered bus response plus the live accept/retry bit.
   always_comb begin
      up_resp     = resp_q;
      up_resp.rty = up_req.cyc & full;
   end

   assign full_o      = full;
   assign empty_o     = (count_q == '0);
   assign count_o     = count_q;
   assign retry_err_o = err_q;

endmodule

// File: tb/tb_fta_req_queue.sv
// Self-checking bench for fta_req_queue against a queue-based reference model.
module tb_fta_req_queue;
   import fta_bus_pkg::*;

   localparam int DEPTH = 4;
   localparam int LIMIT = 15;

   logic                 clk = 1'b0;
   logic                 rst_n;
   fta_cmd_request128_t  up_req;
   fta_cmd_response128_t up_resp;
   fta_cmd_request128_t  dn_req;
   fta_cmd_response128_t dn_resp;
   logic                 full_o;
   logic                 empty_o;
   logic [2:0]           count_o;
   logic                 retry_err_o;

   int checks = 0;
   int errors = 0;

   // Reference model state
   fta_cmd_request128_t  mq[$];
   int                   run_len;
   bit                   merr;
   fta_cmd_response128_t mresp;

   fta_req_queue #(.DEPTH(DEPTH), .RETRY_LIMIT(LIMIT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .up_req      (up_req),
      .up_resp     (up_resp),
      .dn_req      (dn_req),
      .dn_resp     (dn_resp),
      .full_o      (full_o),
      .empty_o     (empty_o),
      .count_o     (count_o),
      .retry_err_o (retry_err_o)
   );

   always #5 clk = ~clk;

   function automatic fta_cmd_request128_t mk_req(bit cyc, logic [31:0] padr);
      fta_cmd_request128_t r;
      r.tid  = 15'($urandom);
      r.cyc  = cyc;
      r.stb  = cyc;
      r.we   = 1'($urandom);
      r.sel  = 16'($urandom);
      r.padr = padr;
      r.dat  = {$urandom, $urandom, $urandom, $urandom};
      return r;
   endfunction

   function automatic fta_cmd_response128_t mk_resp(bit rty);
      fta_cmd_response128_t r;
      r.tid = 15'($urandom);
      r.ack = 1'($urandom);
      r.rty = rty;
      r.adr = $urandom;
      r.dat = {$urandom, $urandom, $urandom, $urandom};
      return r;
   endfunction

   // Compare every DUT output against the model (called between edges).
   task automatic scoreboard(string tag);
      fta_cmd_response128_t exp_resp;
      exp_resp     = mresp;
      exp_resp.rty = up_req.cyc && (mq.size() == DEPTH);
      checks++;
      if (up_resp !== exp_resp) begin
         errors++;
         $display("FAIL %s up_resp: got %h expected %h", tag, up_resp, exp_resp);
      end
      checks++;
      if (count_o !== 3'(mq.size()) || full_o !== (mq.size() == DEPTH) || empty_o !== (mq.size() == 0)) begin
         errors++;
         $display("FAIL %s occupancy: got count=%0d full=%b empty=%b expected count=%0d", tag, count_o, full_o, empty_o, mq.size());
      end
      checks++;
      if (retry_err_o !== merr) begin
         errors++;
         $display("FAIL %s retry_err_o: got %b expected %b", tag, retry_err_o, merr);
      end
      checks++;
      if (mq.size() == 0) begin
         if (dn_req.cyc !== 1'b0) begin
            errors++;
            $display("FAIL %s dn_req.cyc: got %b expected 0", tag, dn_req.cyc);
         end
      end else if (dn_req !== mq[0]) begin
         errors++;
         $display("FAIL %s dn_req: got %h expected %h", tag, dn_req, mq[0]);
      end
   endtask

   // One clock cycle: inputs already driven after a negedge; check, clock, advance model.
   task automatic step(string tag);
      bit                   push, pop, nonempty, rty;
      fta_cmd_request128_t  req;
      fta_cmd_response128_t resp;
      #1;
      scoreboard(tag);
      nonempty = (mq.size() > 0);
      rty      = dn_resp.rty;
      push     = up_req.cyc && (mq.size() < DEPTH);
      pop      = nonempty && !rty;
      req      = up_req;
      resp     = dn_resp;
      @(posedge clk);
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(req);
      if (nonempty) begin
         if (!rty)               run_len = 0;
         else if (run_len < LIMIT) run_len++;
      end
      if (run_len >= LIMIT) merr = 1'b1;
      mresp     = resp;
      mresp.rty = 1'b0;
      @(negedge clk);
   endtask

   task automatic model_clear();
      mq.delete();
      run_len = 0;
      merr    = 1'b0;
      mresp   = '0;
   endtask

   task automatic apply_reset();
      rst_n   = 1'b0;
      up_req  = '0;
      dn_resp = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_clear();
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      checks++;
      if (dn_req !== '0 || up_resp !== '0) begin
         errors++;
         $display("FAIL reset_zero: got dn_req=%h up_resp=%h expected all zero", dn_req, up_resp);
      end
      checks++;
      if (count_o !== 3'd0 || empty_o !== 1'b1 || full_o !== 1'b0 || retry_err_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got count=%0d empty=%b full=%b err=%b expected 0 1 0 0", count_o, empty_o, full_o, retry_err_o);
      end
      step("reset_idle");
   endtask

   task automatic test_single_write();
      up_req    = mk_req(1'b1, 32'h1000);
      up_req.we = 1'b1;
      dn_resp   = mk_resp(1'b0);
      step("single_push");
      up_req  = mk_req(1'b0, 32'h0);
      dn_resp = mk_resp(1'b0);
      #1;
      checks++;
      if (dn_req.cyc !== 1'b1 || dn_req.padr !== 32'h1000 || dn_req.we !== 1'b1 || count_o !== 3'd1) begin
         errors++;
         $display("FAIL single_issue: got cyc=%b padr=%h we=%b count=%0d expected 1 00001000 1 1", dn_req.cyc, dn_req.padr, dn_req.we, count_o);
      end
      step("single_issue");
      #1;
      checks++;
      if (count_o !== 3'd0 || empty_o !== 1'b1 || dn_req.cyc !== 1'b0) begin
         errors++;
         $display("FAIL single_drain: got count=%0d empty=%b cyc=%b expected 0 1 0", count_o, empty_o, dn_req.cyc);
      end
      step("single_after");
   endtask

   task automatic test_response_routing();
      fta_cmd_response128_t r;
      r             = mk_resp(1'b0);
      r.ack         = 1'b1;
      r.tid.channel = 3'd1;
      r.adr         = 32'h1234_5670;
      r.dat         = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
      up_req        = mk_req(1'b0, 32'h0);
      dn_resp       = r;
      step("resp_drive");
      dn_resp = mk_resp(1'b0);
      #1;
      checks++;
      if (up_resp.ack !== 1'b1 || up_resp.tid !== r.tid || up_resp.adr !== r.adr || up_resp.dat !== r.dat || up_resp.rty !== 1'b0) begin
         errors++;
         $display("FAIL resp_route: got %h expected fields of %h with rty=0", up_resp, r);
      end
      step("resp_after");
   endtask

   task automatic test_fill();
      for (int i = 0; i < 5; i++) begin
         up_req  = mk_req(1'b1, 32'h2000 + 32'(i * 16));
         dn_resp = mk_resp(1'b1);
         #1;
         if (i == 4) begin
            checks++;
            if (up_resp.rty !== 1'b1 || full_o !== 1'b1 || count_o !== 3'd4) begin
               errors++;
               $display("FAIL fill_full: got rty=%b full=%b count=%0d expected 1 1 4", up_resp.rty, full_o, count_o);
            end
         end
         if (i >= 1) begin
            checks++;
            if (dn_req.padr !== 32'h2000 || dn_req.cyc !== 1'b1) begin
               errors++;
               $display("FAIL fill_head: got cyc=%b padr=%h expected 1 00002000", dn_req.cyc, dn_req.padr);
            end
         end
         step("fill");
      end
      for (int i = 0; i < 5; i++) begin
         up_req  = mk_req(1'b0, 32'h0);
         dn_resp = mk_resp(1'b0);
         step("fill_drain");
      end
   endtask

   task automatic test_drain_concurrent();
      logic [31:0] seen[$];
      for (int i = 0; i < 2; i++) begin
         up_req  = mk_req(1'b1, 32'(i * 16));
         dn_resp = mk_resp(1'b1);
         step("conc_prefill");
      end
      for (int i = 2; i < 8; i++) begin
         up_req  = mk_req(1'b1, 32'(i * 16));
         dn_resp = mk_resp(1'b0);
         #1;
         checks++;
         if (count_o !== 3'd2) begin
            errors++;
            $display("FAIL conc_count: got %0d expected 2", count_o);
         end
         if (dn_req.cyc) seen.push_back(dn_req.padr);
         step("conc_push");
      end
      for (int i = 0; i < 4; i++) begin
         up_req  = mk_req(1'b0, 32'h0);
         dn_resp = mk_resp(1'b0);
         #1;
         if (dn_req.cyc) seen.push_back(dn_req.padr);
         step("conc_drain");
      end
      checks++;
      if (seen.size() != 8) begin
         errors++;
         $display("FAIL conc_order_len: got %0d pops expected 8", seen.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (seen[i] !== 32'(i * 16)) begin
               errors++;
               $display("FAIL conc_order: pop %0d got padr %h expected %h", i, seen[i], 32'(i * 16));
               break;
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         up_req  = mk_req($urandom_range(0, 3) != 0, $urandom);
         dn_resp = mk_resp($urandom_range(0, 2) == 0);
         step("random");
      end
      for (int i = 0; i < DEPTH + 1; i++) begin
         up_req  = mk_req(1'b0, 32'h0);
         dn_resp = mk_resp(1'b0);
         step("random_drain");
      end
   endtask

   task automatic test_retry_limit();
      apply_reset();
      up_req  = mk_req(1'b1, 32'h3000);
      dn_resp = mk_resp(1'b0);
      step("retry_push");
      for (int k = 1; k <= LIMIT; k++) begin
         up_req  = mk_req(1'b0, 32'h0);
         dn_resp = mk_resp(1'b1);
         step("retry_hold");
         #1;
         checks++;
         if (retry_err_o !== (k == LIMIT)) begin
            errors++;
            $display("FAIL retry_err_rise: after %0d retries got %b expected %b", k, retry_err_o, k == LIMIT);
         end
      end
      dn_resp = mk_resp(1'b0);
      step("retry_release");
      #1;
      checks++;
      if (count_o !== 3'd0 || retry_err_o !== 1'b1) begin
         errors++;
         $display("FAIL retry_sticky: got count=%0d err=%b expected 0 1", count_o, retry_err_o);
      end
      step("retry_after");
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         up_req  = mk_req(1'b1, 32'h4000 + 32'(i * 16));
         dn_resp = mk_resp(1'b1);
         step("areset_fill");
      end
      up_req  = mk_req(1'b0, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (dn_req.cyc !== 1'b0 || count_o !== 3'd0 || empty_o !== 1'b1 || retry_err_o !== 1'b0) begin
         errors++;
         $display("FAIL areset_now: got cyc=%b count=%0d empty=%b err=%b expected 0 0 1 0", dn_req.cyc, count_o, empty_o, retry_err_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      for (int i = 0; i < 6; i++) begin
         up_req  = mk_req(1'b0, 32'h0);
         dn_resp = mk_resp(1'b0);
         #1;
         checks++;
         if (dn_req.cyc !== 1'b0) begin
            errors++;
            $display("FAIL areset_replay: got dn_req.cyc=%b padr=%h expected 0", dn_req.cyc, dn_req.padr);
         end
         step("areset_after");
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      up_req  = '0;
      dn_resp = '0;
      model_clear();
      test_reset();
      test_single_write();
      test_response_routing();
      test_fill();
      test_drain_concurrent();
      test_random();
      test_retry_limit();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fta_req_queue.md
Name: fta_req_queue

Overview:
- Registered request queue between the MPU's arbitrated fta_req output and the system bus.
- Absorbs downstream retry (rty) so the MPU arbiter is released one cycle after a request is accepted.
- Holds the head request stable on the bus until it is taken.
- Routes bus responses back upstream through one register stage and flags a stuck head with a sticky error.

Parameters:
- DEPTH, 4: number of queued requests; must be a power of two, at least 2.
- RETRY_LIMIT, 15: consecutive downstream rty cycles on one head entry before retry_err_o is set.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset. One clock; reset is asynchronous and active-low.
- up_req, input, fta_cmd_request128_t: request from the MPU arbiter.
- up_resp, output, fta_cmd_response128_t: accept/retry indication plus routed bus response to the MPU.
- dn_req, output, fta_cmd_request128_t: request to the system bus.
- dn_resp, input, fta_cmd_response128_t: response from the system bus.
- full_o, output, 1: queue holds DEPTH entries.
- empty_o, output, 1: queue holds 0 entries.
- count_o, output, $clog2(DEPTH)+1: current occupancy.
- retry_err_o, output, 1: sticky flag; head entry exceeded RETRY_LIMIT.

Behaviour:
- Reset (rst_n low, async):
  - Pointers and count go to 0; FSM goes to IDLE; retry counter goes to 0.
  - dn_req becomes all-zero; up_resp becomes all-zero; retry_err_o becomes 0.
  - full_o=0, empty_o=1.
  - Reset mid-transfer flushes every queued entry and does not replay them.
- Push (upstream):
  - Push when up_req.cyc=1 and full_o=0; the whole request struct is written at wr_ptr.
  - up_resp.rty is combinational: rty = up_req.cyc & full_o.
  - rty does not depend on the same-cycle pop. No path from dn_resp to up_resp.rty.
  - Every cycle with up_req.cyc=1 and rty=0 is one accepted request. The upstream must present a new request or drop cyc on the next cycle.
- Pop (downstream):
  - FSM states: IDLE, ISSUE, STALL.
  - IDLE: dn_req.cyc=0. Go to ISSUE on the next edge when count is non-zero.
  - ISSUE/STALL: dn_req = entry at rd_ptr, held bit-stable.
  - If dn_resp.rty=0 in a cycle: pop and clear the retry counter. Stay in ISSUE if more than one entry remains, else go to IDLE.
  - If dn_resp.rty=1: go to or stay in STALL and increment the retry counter (saturates at RETRY_LIMIT).
  - When the retry counter reaches RETRY_LIMIT, retry_err_o is set. It stays set until reset.
- Latency:
  - Accept to dn_req.cyc=1 is 1 cycle minimum; there is no bypass when empty.
  - Back-to-back pops give one request per cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is one bit wider.
- Response path:
  - dn_resp is registered one cycle and driven on up_resp, with tid, ack, adr and dat unchanged.
  - The registered response's rty field is forced to 0; up_resp.rty comes only from the push logic.
  - Responses are never dropped or reordered.
- The queue carries requests and is never consulted for responses.

Decomposition:
- fta_cmd_request128_t and fta_cmd_response128_t come from fta_bus_pkg; no new package.
- The FSM state enum is local to the module.
- Sub-module fta_reqq_store: DEPTH x request-width register array with one write port and one async read port, no reset on data.

Test Plan:
- Single write: push padr=0x1000, we=1, dn_resp.rty=0 -> dn_req.cyc=1 exactly 1 cycle after accept with padr=0x1000; count_o returns 1 then 0; empty_o=1 after.
- Fill: 5 consecutive pushes with dn_resp.rty=1, DEPTH=4 -> first 4 accepted; 5th sees up_resp.rty=1; full_o=1, count_o=4; dn_req holds entry 0 stable throughout.
- Drain with concurrent push: release rty while pushing 1 request per cycle from count=2 -> count_o stays 2; dn_req order matches push order across pointer wrap (8 requests, padr 0x00..0x70).
- Retry limit: hold dn_resp.rty=1 for 15 cycles on the head -> retry_err_o=1 on the 15th; drop rty -> pop occurs, retry_err_o stays 1.
- Response routing: dn_resp ack=1, tid.channel=1, dat=0xDEADBEEF... -> up_resp shows identical fields 1 cycle later with rty=0.
- Async reset mid-stall: rst_n low with 3 entries queued -> dn_req.cyc=0, count_o=0, empty_o=1 immediately with no clock edge; no queued request appears after reset release.
